// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit's memory master and the memory responder.
// The master drives the request; the slave drives completion, status and read data.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  enable;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] datain;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  ready;
    logic                  error;

    modport master (
        output enable, write, addr, datain,
        input  dataout, ready, error
    );

    modport slave (
        input  enable, write, addr, datain,
        output dataout, ready, error
    );
endinterface

// File: rtl/mem_responder.sv
// Slow-memory model answering CU requests over a four-phase enable/ready handshake,
// with a programmable number of wait cycles before each access and out-of-range flagging.
module mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 200,
    parameter int LATENCY    = 2
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int                  CNT_W   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0]    LAT_CNT = CNT_W'(LATENCY);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] datain_q;
    logic [DATA_WIDTH-1:0] dataout_q;
    logic                  ready_q;
    logic                  error_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic in_range;
    logic access;
    logic mem_we;

    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign access   = (state_q == BUSY) && (cnt_q == '0);
    // Gating with reset keeps an aborted write from ever landing in the array.
    assign mem_we   = access && write_q && in_range && !reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= datain_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            dataout_q <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        write_q  <= bus.write;
                        addr_q   <= bus.addr;
                        datain_q <= bus.datain;
                        cnt_q    <= LAT_CNT;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= DONE;
                        if (!in_range) begin
                            error_q   <= 1'b1;
                            dataout_q <= '0;
                        end else begin
                            error_q <= 1'b0;
                            if (!write_q) begin
                                dataout_q <= mem[addr_q];
                            end
                        end
                    end
                end
                DONE: begin
                    // Stay here while enable is held so one handshake yields exactly one access.
                    if (!bus.enable) begin
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dataout = dataout_q;
    assign bus.ready   = ready_q;
    assign bus.error   = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with LATENCY=2 and one with LATENCY=0, checked
// against a reference memory model through an expected-result queue.
module tb_mem_responder;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 200;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(2)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );
    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(0)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    logic          en [2];
    logic          wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] di [2];
    logic          rdy [2];
    logic          err [2];
    logic [DW-1:0] dout [2];

    assign bus0.enable = en[0];
    assign bus0.write  = wr[0];
    assign bus0.addr   = ad[0];
    assign bus0.datain = di[0];
    assign bus1.enable = en[1];
    assign bus1.write  = wr[1];
    assign bus1.addr   = ad[1];
    assign bus1.datain = di[1];
    assign rdy[0]  = bus0.ready;
    assign err[0]  = bus0.error;
    assign dout[0] = bus0.dataout;
    assign rdy[1]  = bus1.ready;
    assign err[1]  = bus1.error;
    assign dout[1] = bus1.dataout;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb [$];
    int            lat_of [2] = '{2, 0};
    logic [DW-1:0] model_mem [2][256];
    logic [DW-1:0] last_dout [2];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. mode 0: normal handshake; 1: corrupt inputs during BUSY; 2: drop enable during BUSY.
    task automatic req(input int s, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int mode);
        exp_t e;
        int   cyc;
        en[s] = 1'b1;
        wr[s] = w;
        ad[s] = a;
        di[s] = d;
        if (a >= AW'(DEPTH)) begin
            e.data = '0;
            e.err  = 1'b1;
        end else if (w) begin
            model_mem[s][a] = d;
            e.data = last_dout[s];
            e.err  = 1'b0;
        end else begin
            e.data = model_mem[s][a];
            e.err  = 1'b0;
        end
        last_dout[s] = e.data;
        sb.push_back(e);
        $display("txn dut%0d %s addr=%0d data=0x%0h mode=%0d", s, w ? "WR" : "RD", a, d, mode);

        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (!rdy[s] && cyc == 1) begin
                if (mode == 1) begin
                    ad[s] = a + AW'(2);
                    di[s] = ~d;
                    wr[s] = ~w;
                end
                if (mode == 2) en[s] = 1'b0;
            end
        end while (!rdy[s] && cyc < 20);

        e = sb.pop_front();
        check($sformatf("latency dut%0d a=%0d", s, a), 64'(cyc), 64'(lat_of[s] + 2));
        check($sformatf("data dut%0d a=%0d", s, a), 64'(dout[s]), 64'(e.data));
        check($sformatf("error dut%0d a=%0d", s, a), 64'(err[s]), 64'(e.err));

        if (mode == 2) begin
            @(negedge clock);
            check($sformatf("pulse dut%0d", s), 64'(rdy[s]), 64'd0);
            check($sformatf("pulse data dut%0d", s), 64'(dout[s]), 64'(e.data));
        end else begin
            @(negedge clock);
            check($sformatf("hold ready dut%0d", s), 64'(rdy[s]), 64'd1);
            check($sformatf("hold data dut%0d", s), 64'(dout[s]), 64'(e.data));
            en[s] = 1'b0;
            @(negedge clock);
            check($sformatf("release ready dut%0d", s), 64'(rdy[s]), 64'd0);
            check($sformatf("release error dut%0d", s), 64'(err[s]), 64'd0);
            check($sformatf("release data dut%0d", s), 64'(dout[s]), 64'(e.data));
        end
    endtask

    // Write issued on dut0, then reset lands while the wait counter is still running.
    task automatic abort_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        en[0] = 1'b1;
        wr[0] = 1'b1;
        ad[0] = a;
        di[0] = d;
        $display("txn dut0 WR addr=%0d data=0x%0h aborted by reset", a, d);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort ready", 64'(rdy[0]), 64'd0);
        check("abort error", 64'(err[0]), 64'd0);
        check("abort data", 64'(dout[0]), 64'd0);
        reset = 1'b0;
        en[0] = 1'b0;
        last_dout[0] = '0;
        last_dout[1] = '0;
        @(negedge clock);
        check("abort idle", 64'(rdy[0]), 64'd0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            en[s] = 1'b0;
            wr[s] = 1'b0;
            ad[s] = '0;
            di[s] = '0;
            last_dout[s] = '0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            for (int s = 0; s < 2; s++) begin
                check($sformatf("reset ready dut%0d c%0d", s, c), 64'(rdy[s]), 64'd0);
                check($sformatf("reset error dut%0d c%0d", s, c), 64'(err[s]), 64'd0);
                check($sformatf("reset data dut%0d c%0d", s, c), 64'(dout[s]), 64'd0);
            end
        end

        req(0, 1'b1, 8'd5,   32'hDEADBEEF, 0);
        req(0, 1'b0, 8'd5,   32'h0,        0);
        req(0, 1'b1, 8'd199, 32'h11,       0);
        req(0, 1'b0, 8'd199, 32'h0,        0);
        req(0, 1'b1, 8'd200, 32'h77,       0);
        req(0, 1'b0, 8'd200, 32'h0,        0);
        req(0, 1'b0, 8'd199, 32'h0,        0);
        req(0, 1'b0, 8'd5,   32'h12345678, 1);
        req(0, 1'b0, 8'd7,   32'h0,        0);
        req(0, 1'b0, 8'd5,   32'h0,        2);
        req(0, 1'b1, 8'd9,   32'h0,        0);
        abort_write(8'd9, 32'h55);
        req(0, 1'b0, 8'd9,   32'h0,        0);

        req(1, 1'b1, 8'd3,   32'hA5A5A5A5, 0);
        req(1, 1'b0, 8'd3,   32'h0,        0);
        req(1, 1'b1, 8'd4,   32'h00001234, 0);
        req(1, 1'b0, 8'd4,   32'h0,        0);
        req(1, 1'b0, 8'd3,   32'h0,        0);
        req(1, 1'b1, 8'd255, 32'hCAFE,     0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
